// File: rtl/game_sequencer.sv
// Round sequencer for the code-entry bomb game: shows a random code, arms a
// countdown for entry, holds the result, then auto-restarts into IDLE.
module game_sequencer #(
  parameter int SHOW_SEC    = 5,
  parameter int ARM_SEC     = 20,
  parameter int HOLD_SEC    = 3,
  parameter int MAX_STRIKES = 3
) (
  input  logic       clk,
  input  logic       rst_p,
  input  logic       sw_en,
  input  logic       btn_start,
  input  logic       tick_1hz,
  input  logic       code_ok,
  input  logic       code_bad,
  output logic [4:0] code,
  output logic       show_en,
  output logic       input_en,
  output logic       bomb_en,
  output logic [4:0] secs_left,
  output logic [1:0] strikes,
  output logic       fail,
  output logic       success,
  output logic       sub_rst
);

  typedef enum logic [2:0] {
    IDLE,
    SHOW,
    ARM,
    FAIL,
    SUCCESS
  } state_t;

  localparam logic [4:0] SHOW_L = 5'(SHOW_SEC);
  localparam logic [4:0] ARM_L  = 5'(ARM_SEC);
  localparam logic [4:0] HOLD_L = 5'(HOLD_SEC);
  localparam logic [1:0] MAX_L  = 2'(MAX_STRIKES);

  state_t     state, state_d;
  logic [4:0] lfsr;
  logic [4:0] code_d, secs_d;
  logic [1:0] strikes_d;
  logic       sub_rst_d;
  logic       btn_q, sw_en_q;

  always_comb begin
    state_d   = state;
    code_d    = code;
    secs_d    = secs_left;
    strikes_d = strikes;
    sub_rst_d = 1'b0;
    if (!sw_en) begin
      state_d   = IDLE;
      secs_d    = '0;
      strikes_d = '0;
      sub_rst_d = sw_en_q;
    end else begin
      unique case (state)
        IDLE: begin
          if (btn_start && !btn_q) begin
            state_d   = SHOW;
            code_d    = lfsr;
            strikes_d = '0;
            secs_d    = SHOW_L;
            sub_rst_d = 1'b1;
          end
        end
        SHOW: begin
          if (tick_1hz) begin
            if (secs_left <= 5'd1) begin
              state_d = ARM;
              secs_d  = ARM_L;
            end else begin
              secs_d = secs_left - 5'd1;
            end
          end
        end
        ARM: begin
          if (code_ok) begin
            state_d = SUCCESS;
            secs_d  = HOLD_L;
          end else begin
            if (tick_1hz) secs_d = secs_left - 5'd1;
            if (code_bad && strikes != MAX_L) strikes_d = strikes + 2'd1;
            // A strike-out loads the hold time directly; a timeout shows 0 first.
            if (code_bad && strikes_d == MAX_L) begin
              state_d = FAIL;
              secs_d  = HOLD_L;
            end else if (tick_1hz && secs_left == 5'd1) begin
              state_d = FAIL;
              secs_d  = '0;
            end
          end
        end
        FAIL, SUCCESS: begin
          if (secs_left == 5'd0) begin
            secs_d = HOLD_L;
          end else if (tick_1hz) begin
            if (secs_left == 5'd1) begin
              state_d   = IDLE;
              secs_d    = '0;
              strikes_d = '0;
              sub_rst_d = 1'b1;
            end else begin
              secs_d = secs_left - 5'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed by the comb block above.
  always_ff @(posedge clk) begin
    // Edge detectors track their inputs even in reset, so a button held
    // across reset release does not start a phantom round.
    btn_q   <= btn_start;
    sw_en_q <= sw_en;
    if (rst_p) begin
      state     <= IDLE;
      lfsr      <= 5'b00001;
      code      <= '0;
      secs_left <= '0;
      strikes   <= '0;
      show_en   <= 1'b0;
      input_en  <= 1'b0;
      bomb_en   <= 1'b0;
      fail      <= 1'b0;
      success   <= 1'b0;
      sub_rst   <= 1'b1;
    end else begin
      lfsr      <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
      state     <= state_d;
      code      <= code_d;
      secs_left <= secs_d;
      strikes   <= strikes_d;
      show_en   <= (state_d == SHOW);
      input_en  <= (state_d == ARM);
      bomb_en   <= (state_d == SHOW) || (state_d == ARM);
      fail      <= (state_d == FAIL);
      success   <= (state_d == SUCCESS);
      sub_rst   <= sub_rst_d;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a rule-level game model queues the
// expected outputs of every cycle; a monitor pops and compares them.
module tb_game_sequencer;

  localparam int SHOW_SEC = 5, ARM_SEC = 20, HOLD_SEC = 3, MAX_STRIKES = 3;

  logic       clk = 1'b0;
  logic       rst_p = 1'b1, sw_en = 1'b1, btn_start = 1'b0;
  logic       tick_1hz = 1'b0, code_ok = 1'b0, code_bad = 1'b0;
  logic [4:0] code, secs_left;
  logic [1:0] strikes;
  logic       show_en, input_en, bomb_en, fail, success, sub_rst;

  game_sequencer #(
    .SHOW_SEC(SHOW_SEC), .ARM_SEC(ARM_SEC), .HOLD_SEC(HOLD_SEC), .MAX_STRIKES(MAX_STRIKES)
  ) dut (
    .clk(clk), .rst_p(rst_p), .sw_en(sw_en), .btn_start(btn_start),
    .tick_1hz(tick_1hz), .code_ok(code_ok), .code_bad(code_bad),
    .code(code), .show_en(show_en), .input_en(input_en), .bomb_en(bomb_en),
    .secs_left(secs_left), .strikes(strikes), .fail(fail), .success(success),
    .sub_rst(sub_rst)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t act code=%b show/in/bomb=%b secs=%0d strk=%0d fail/succ=%b sub=%b | req code=%b show/in/bomb=%b secs=%0d strk=%0d fail/succ=%b sub=%b",
               name, $time, act[17:13], act[12:10], act[9:5], act[4:3], act[2:1], act[0],
               req[17:13], req[12:10], req[9:5], req[4:3], req[2:1], req[0]);
    end
  endtask

  // ---------------- reference model: game rules at phase level -------------
  typedef enum int {P_IDLE, P_SHOW, P_ARM, P_FAIL, P_SUCCESS} phase_t;

  logic [17:0] exp_q[$];
  phase_t     m_phase = P_IDLE;
  int         m_secs = 0, m_strk = 0;
  logic [4:0] m_code = '0, m_lfsr = 5'b00001;
  bit         m_btn_q = 1'b0, m_sw_q = 1'b0, m_sub;

  function automatic logic [4:0] lfsr_next(input logic [4:0] v);
    // x^5 + x^3 + 1 : new bit is the xor of stages 5 and 3
    return {v[3:0], v[4] ^ v[2]};
  endfunction

  always @(posedge clk) begin
    m_sub = 1'b0;
    if (rst_p) begin
      m_phase = P_IDLE; m_lfsr = 5'b00001; m_code = '0;
      m_secs = 0; m_strk = 0; m_sub = 1'b1;
    end else begin
      if (!sw_en) begin
        m_phase = P_IDLE; m_secs = 0; m_strk = 0; m_sub = m_sw_q;
      end else if (m_phase == P_IDLE) begin
        if (btn_start && !m_btn_q) begin
          m_phase = P_SHOW; m_code = m_lfsr; m_strk = 0; m_secs = SHOW_SEC; m_sub = 1'b1;
        end
      end else if (m_phase == P_SHOW) begin
        if (tick_1hz && m_secs == 1) begin m_phase = P_ARM; m_secs = ARM_SEC; end
        else if (tick_1hz) m_secs--;
      end else if (m_phase == P_ARM) begin
        if (code_ok) begin
          m_phase = P_SUCCESS; m_secs = HOLD_SEC;
        end else if (code_bad && m_strk + 1 >= MAX_STRIKES) begin
          m_strk = MAX_STRIKES; m_phase = P_FAIL; m_secs = HOLD_SEC;
        end else begin
          if (code_bad) m_strk++;
          if (tick_1hz && m_secs == 1) begin m_phase = P_FAIL; m_secs = 0; end
          else if (tick_1hz) m_secs--;
        end
      end else begin
        if (m_secs == 0) m_secs = HOLD_SEC;
        else if (tick_1hz && m_secs == 1) begin
          m_phase = P_IDLE; m_secs = 0; m_strk = 0; m_sub = 1'b1;
        end else if (tick_1hz) m_secs--;
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
    m_btn_q = btn_start;
    m_sw_q  = sw_en;
    exp_q.push_back({m_code,
                     m_phase == P_SHOW, m_phase == P_ARM, m_phase == P_SHOW || m_phase == P_ARM,
                     5'(m_secs), 2'(m_strk),
                     m_phase == P_FAIL, m_phase == P_SUCCESS, m_sub});
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [17:0] req;
      req = exp_q.pop_front();
      check("cycle_outputs",
            {code, show_en, input_en, bomb_en, secs_left, strikes, fail, success, sub_rst}, req);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit t, input bit ok, input bit bad);
    @(negedge clk);
    tick_1hz = t; code_ok = ok; code_bad = bad;
  endtask

  task automatic idle_n(input int n);
    repeat (n) cyc(0, 0, 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin cyc(1, 0, 0); idle_n(2); end
  endtask

  task automatic press;
    @(negedge clk); btn_start = 1'b0;
    idle_n(2);
    @(negedge clk); btn_start = 1'b1;
    idle_n(2);
  endtask

  initial begin
    idle_n(3);
    @(negedge clk); rst_p = 1'b0;
    idle_n(33);                         // full LFSR period before the first round

    press; ticks(SHOW_SEC); ticks(ARM_SEC - 1);
    cyc(1, 1, 0); idle_n(2);            // code_ok and last tick together
    ticks(HOLD_SEC); idle_n(2);

    press; ticks(SHOW_SEC);
    repeat (3) begin cyc(0, 0, 1); idle_n(3); end
    ticks(HOLD_SEC); idle_n(2);

    press; ticks(SHOW_SEC); ticks(ARM_SEC); idle_n(2);
    ticks(HOLD_SEC); idle_n(2);

    press; ticks(2);
    @(negedge clk); sw_en = 1'b0;        // btn still held
    idle_n(4);
    @(negedge clk); sw_en = 1'b1;
    idle_n(4);
    press; ticks(SHOW_SEC); ticks(3);

    @(negedge clk); rst_p = 1'b1;        // mid-round reset
    idle_n(2);
    @(negedge clk); rst_p = 1'b0;
    idle_n(3);

    repeat (4000) begin
      @(negedge clk);
      rst_p     = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 79) == 0) sw_en = ~sw_en;
      else if (!sw_en && $urandom_range(0, 7) == 0) sw_en = 1'b1;
      if ($urandom_range(0, 11) == 0) btn_start = ~btn_start;
      tick_1hz  = ($urandom_range(0, 5) == 0);
      code_ok   = ($urandom_range(0, 59) == 0);
      code_bad  = ($urandom_range(0, 24) == 0);
    end

    idle_n(3);
    @(posedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
